// File: rtl/lc3b_ctrl_fsm.sv
// rtl/lc3b_ctrl_fsm.sv - LC-3b control microsequencer with memory-wait timeout and illegal-opcode trap
`timescale 1ns/1ps
module lc3b_ctrl_fsm #(
    parameter int STATE_W      = 6,
    parameter int MEM_TIMEOUT  = 15,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        IR,
    input  logic               R,
    input  logic               BEN,
    output logic [STATE_W-1:0] stateID,
    output logic               mem_en,
    output logic               mem_we,
    output logic               ld_ir,
    output logic               err_timeout,
    output logic               err_illegal
);

    typedef enum logic [5:0] {
        S_BR        = 6'd0,
        S_ADD       = 6'd1,
        S_JSR       = 6'd4,
        S_AND       = 6'd5,
        S_LDW       = 6'd6,
        S_STW       = 6'd7,
        S_XOR       = 6'd9,
        S_JMP       = 6'd12,
        S_LEA       = 6'd14,
        S_STW_MEM   = 6'd16,
        S_FETCH0    = 6'd18,
        S_FETCH1    = 6'd19,
        S_JSR_R     = 6'd20,
        S_JSR_I     = 6'd21,
        S_BR_T      = 6'd22,
        S_STW_ADDR  = 6'd23,
        S_LDW_MEM   = 6'd25,
        S_LDW_WB    = 6'd27,
        S_DECODE    = 6'd32,
        S_FETCH_MEM = 6'd33,
        S_LD_IR     = 6'd35,
        S_ERR       = 6'd63
    } state_t;

    // Width stays at least 1 so a disabled timeout still yields a legal counter.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLIM = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic          in_wait;
    logic          to_timeout;
    logic          illegal;
    logic          unused_ir;

    assign unused_ir = ^IR[10:0];
    assign stateID   = STATE_W'(state);
    assign in_wait   = (state == S_FETCH_MEM) || (state == S_LDW_MEM) || (state == S_STW_MEM);

    always_comb begin
        nxt        = state;
        to_timeout = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH0:    nxt = S_FETCH1;
            S_FETCH1:    nxt = S_FETCH_MEM;
            S_FETCH_MEM: if (R) nxt = S_LD_IR;
            S_LD_IR:     nxt = S_DECODE;
            S_DECODE: begin
                case (IR[15:12])
                    4'b0000: nxt = S_BR;
                    4'b0001: nxt = S_ADD;
                    4'b0101: nxt = S_AND;
                    4'b1001: nxt = S_XOR;
                    4'b1110: nxt = S_LEA;
                    4'b1100: nxt = S_JMP;
                    4'b0100: nxt = S_JSR;
                    4'b0110: nxt = S_LDW;
                    4'b0111: nxt = S_STW;
                    default: begin
                        if (TRAP_ILLEGAL != 0) begin
                            nxt     = S_ERR;
                            illegal = 1'b1;
                        end else begin
                            nxt = S_FETCH0;
                        end
                    end
                endcase
            end
            S_BR:        nxt = BEN ? S_BR_T : S_FETCH0;
            S_JSR:       nxt = IR[11] ? S_JSR_I : S_JSR_R;
            S_LDW:       nxt = S_LDW_MEM;
            S_LDW_MEM:   if (R) nxt = S_LDW_WB;
            S_STW:       nxt = S_STW_ADDR;
            S_STW_ADDR:  nxt = S_STW_MEM;
            S_STW_MEM:   if (R) nxt = S_FETCH0;
            S_ADD, S_AND, S_XOR, S_LEA, S_JMP,
            S_BR_T, S_JSR_R, S_JSR_I, S_LDW_WB:
                         nxt = S_FETCH0;
            S_ERR:       nxt = S_ERR;
            default:     nxt = S_FETCH0;
        endcase
        // A ready on the deadline edge still completes the access normally.
        if (in_wait && !R && (MEM_TIMEOUT != 0) && (cnt == TLIM)) begin
            nxt        = S_ERR;
            to_timeout = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FETCH0;
            cnt         <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            ld_ir       <= 1'b0;
            err_timeout <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state)
                cnt <= '0;
            else if (in_wait && !R)
                cnt <= cnt + 1'b1;
            err_timeout <= err_timeout | to_timeout;
            err_illegal <= err_illegal | illegal;
            // Outputs are registered from the next state so they track stateID exactly.
            mem_en <= (nxt == S_FETCH_MEM) || (nxt == S_LDW_MEM) || (nxt == S_STW_MEM);
            mem_we <= (nxt == S_STW_MEM);
            ld_ir  <= (nxt == S_LD_IR);
        end
    end

endmodule

// File: doc/lc3b_ctrl_fsm.md
# lc3b_ctrl_fsm

Parametrised LC-3b control microsequencer: drives the datapath through fetch, decode and execute states for the core instruction set, using LC-3b microarchitecture state numbering on `stateID`. Adds memory-ready waits on every memory state, a bounded memory-wait timeout and illegal-opcode trapping. It sits between the memory interface (`R`) and the datapath control-signal decoder, which keys off `stateID`.

## Interface
- `STATE_W`, 6: width of `stateID`; must be ≥ 6.
- `MEM_TIMEOUT`, 15: maximum cycles spent in one memory-wait state before error; 0 disables the timeout.
- `TRAP_ILLEGAL`, 1: 1 sends unsupported opcodes to the error state; 0 returns them to fetch (state 18).
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `IR`  in  16  instruction register; only `IR[15:12]` and `IR[11]` are used.
- `R`  in  1  memory ready, sampled at the rising edge.
- `BEN`  in  1  branch-enable from the datapath, valid while in state 32.
- `stateID`  out  STATE_W  current microstate.
- `mem_en`  out  1  memory access active; high in states 33, 25 and 16.
- `mem_we`  out  1  memory write; high in state 16 only.
- `ld_ir`  out  1  high in state 35.
- `err_timeout`  out  1  sticky; memory wait timed out.
- `err_illegal`  out  1  sticky; illegal opcode decoded (only when TRAP_ILLEGAL=1).

## Operation
- Moore machine. All outputs decode combinationally from the registered state and the sticky flags. Inputs never drive outputs directly.
- Fetch path: 18→19→33. State 33 holds until `R`=1, then →35→32.
- Decode (state 32), dispatch on `IR[15:12]`:
  - 0000 BR→0; 0001 ADD→1; 0101 AND→5; 1001 XOR→9; 1110 LEA→14; 1100 JMP→12; 0100 JSR→4; 0110 LDW→6; 0111 STW→7.
  - Any other opcode goes to 63 if TRAP_ILLEGAL=1, else to 18.
- Execute:
  - BR: 0→22 if `BEN`=1, else 0→18. 22→18.
  - ADD, AND, XOR, LEA, JMP (states 1, 5, 9, 14, 12): →18.
  - JSR: 4→21 if `IR[11]`=1, else 4→20. 20 and 21 →18.
  - LDW: 6→25. State 25 holds until `R`=1, then →27→18.
  - STW: 7→23→16. State 16 holds until `R`=1, then →18.
- Wait counter, width clog2(MEM_TIMEOUT+1):
  - Cleared on any state change.
  - Increments each cycle spent in 33, 25 or 16 with `R`=0.
- Timeout:
  - In a wait state with `R`=0 and count = MEM_TIMEOUT−1, next state is 63 and `err_timeout` sets.
  - If `R`=1 on that same edge, `R` wins: normal transition, no error.
- Error state 63: absorbing. `mem_en`, `mem_we` and `ld_ir` are low. The flags hold until reset.
- Any unlisted state value goes to 18 on the next edge.
- `stateID` is zero-extended to STATE_W.

## Timing
- Reset value of every output: `stateID`=18, `mem_en`=0, `mem_we`=0, `ld_ir`=0, `err_timeout`=0, `err_illegal`=0. The wait counter resets to 0.
- Reset assertion takes effect immediately, mid-instruction or mid-wait; the pending memory access is abandoned.
- After reset deassertion, the first rising edge moves 18→19.
- Memory handshake: a wait state is entered at edge N, and `mem_en` is high from N.
  - `R` sampled high at edge N+k (k ≥ 1) leaves the state at that edge.
  - `R` high at the first edge gives one cycle in the wait state.
- Instruction latency, with `R` high at the first wait edge, counted from entering 18 to re-entering 18:
  - ADD: 6 cycles.
  - BR taken: 7 cycles.
  - LDW: 8 cycles.
  - STW: 8 cycles.
  - Each extra `R`=0 cycle adds 1.
- With MEM_TIMEOUT=T, the machine spends at most T cycles in one wait state before entering 63.

## Test plan
- Reset: hold `reset`=0 → all outputs at reset values and `stateID`=18. Release, `R`=1, `IR`=0x1000 → sequence 18,19,33,35,32,1,18.
- LDW with delayed ready: `IR`=0x6000, `R`=0 for 3 cycles in state 25 → 25 held 4 cycles with `mem_en`=1, then 27, then 18.
- STW: `IR`=0x7000, `R`=1 → 7,23,16,18, with `mem_we`=1 only during 16.
- Timeout, MEM_TIMEOUT=4, `R` held 0 in state 33 → 63 after 4 cycles in 33. `err_timeout`=1 and stays 1. Repeat with `R`=1 on the 4th edge → 35, no error.
- Illegal opcode `IR`=0xD000:
  - TRAP_ILLEGAL=1 → 63 and `err_illegal`=1.
  - TRAP_ILLEGAL=0 → 18 and flags 0.
- BR and JSR: `IR`=0x0000 with `BEN`=1 → 0,22,18; with `BEN`=0 → 0,18. `IR`=0x4800 → 4,21. Assert `reset`=0 mid-state 25 → `stateID`=18 immediately.
